// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures hs/vs timing, tracks lock,
// and rebuilds active-pixel coordinates from blank_n.
module vga_sync_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hs,
    input  logic          vs,
    input  logic          blank_n,
    output logic [CW-1:0] h_period,
    output logic [CW-1:0] h_sync_len,
    output logic [CW-1:0] v_lines,
    output logic [CW-1:0] v_sync_len,
    output logic          line_strobe,
    output logic          frame_strobe,
    output logic          locked,
    output logic          err_h,
    output logic          err_v,
    output logic [9:0]    px_x,
    output logic [9:0]    px_y,
    output logic          px_valid
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [CW-1:0] CMAX   = '1;
    localparam logic [CW-1:0] HS_C   = CW'(H_SYNC);
    localparam logic [CW-1:0] HT_C   = CW'(H_TOTAL);
    localparam logic [CW-1:0] VS_C   = CW'(V_SYNC);
    localparam logic [CW-1:0] VT_C   = CW'(V_TOTAL);
    localparam logic [CW-1:0] VT2_C  = CW'(2 * V_TOTAL);
    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t state_q, state_d;

    logic s_hs_q, s_hs_d;
    logic s_vs_q, s_vs_d;
    logic s_blank_q, s_blank_d;
    logic p_hs_q, p_hs_d;
    logic p_vs_q, p_vs_d;

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic [CW-1:0] l_cnt_q, l_cnt_d;
    logic [CW-1:0] vl_cnt_q, vl_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;

    logic h_seen_q, h_seen_d;
    logic v_seen_q, v_seen_d;
    logic hlen_valid_q, hlen_valid_d;
    logic frame_bad_q, frame_bad_d;
    logic line_act_q, line_act_d;

    logic [CW-1:0] h_period_q, h_period_d;
    logic [CW-1:0] h_sync_len_q, h_sync_len_d;
    logic [CW-1:0] v_lines_q, v_lines_d;
    logic [CW-1:0] v_sync_len_q, v_sync_len_d;

    logic line_strobe_q, line_strobe_d;
    logic frame_strobe_q, frame_strobe_d;
    logic err_h_q, err_h_d;
    logic err_v_q, err_v_d;

    logic [9:0] px_x_q, px_x_d;
    logic [9:0] px_y_q, px_y_d;

    logic          hfall, hrise, vfall;
    logic          measure_h, checking;
    logic          line_ok, frame_ok;
    logic          bad_line, bad_frame;
    logic          timeout;
    logic [CW-1:0] h_next;

    always_comb begin
        hfall     = p_hs_q & ~s_hs_q;
        hrise     = ~p_hs_q & s_hs_q;
        vfall     = p_vs_q & ~s_vs_q;
        measure_h = hfall & h_seen_q;
        checking  = (state_q != SEARCH);
        h_next    = h_cnt_q + 1'b1;

        line_ok  = (h_next == HT_C) && (h_sync_len_q == HS_C)
                && hlen_valid_q;
        frame_ok = (l_cnt_q == VT_C) && (vl_cnt_q == VS_C)
                && !frame_bad_q;

        bad_line  = measure_h && !line_ok && checking;
        bad_frame = vfall && v_seen_q && !frame_ok && checking;

        // An hfall clears h_cnt this cycle, so a saturated count that is
        // ending must not also wipe the h_seen it is about to set.
        timeout = ((h_cnt_q == CMAX) && !hfall) || (l_cnt_q == VT2_C);
    end

    always_comb begin
        s_hs_d    = hs;
        s_vs_d    = vs;
        s_blank_d = blank_n;
        p_hs_d    = s_hs_q;
        p_vs_d    = s_vs_q;

        h_cnt_d      = h_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        l_cnt_d      = l_cnt_q;
        vl_cnt_d     = vl_cnt_q;
        h_seen_d     = h_seen_q;
        hlen_valid_d = hlen_valid_q;
        frame_bad_d  = frame_bad_q;
        h_period_d   = h_period_q;
        h_sync_len_d = h_sync_len_q;
        v_lines_d    = v_lines_q;
        v_sync_len_d = v_sync_len_q;

        line_strobe_d  = measure_h;
        frame_strobe_d = vfall;
        err_h_d        = bad_line;
        err_v_d        = bad_frame;

        if (hfall) begin
            h_cnt_d  = '0;
            h_seen_d = 1'b1;
        end else if (h_cnt_q != CMAX) begin
            h_cnt_d = h_next;
        end
        if (measure_h) begin
            h_period_d = h_next;
        end

        if (hrise) begin
            lo_cnt_d     = '0;
            h_sync_len_d = lo_cnt_q;
            hlen_valid_d = 1'b1;
        end else if (!s_hs_q && lo_cnt_q != CMAX) begin
            lo_cnt_d = lo_cnt_q + 1'b1;
        end

        // A line starting on the vfall cycle belongs to the new frame.
        if (vfall) begin
            l_cnt_d     = measure_h ? CW'(1) : '0;
            vl_cnt_d    = measure_h ? CW'(1) : '0;
            frame_bad_d = 1'b0;
            if (v_seen_q) begin
                v_lines_d    = l_cnt_q;
                v_sync_len_d = vl_cnt_q;
            end
        end else if (measure_h) begin
            l_cnt_d = l_cnt_q + 1'b1;
            if (!s_vs_q) begin
                vl_cnt_d = vl_cnt_q + 1'b1;
            end
        end
        if (bad_line) begin
            frame_bad_d = 1'b1;
        end

        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        v_seen_d   = v_seen_q;
        unique case (state_q)
            SEARCH: begin
                if (vfall) begin
                    v_seen_d   = 1'b1;
                    good_cnt_d = '0;
                    state_d    = MEASURE;
                end
            end
            MEASURE: begin
                if (vfall) begin
                    if (bad_frame) begin
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_d == LOCK_C) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (bad_line || bad_frame) begin
                    good_cnt_d = '0;
                    state_d    = MEASURE;
                end
            end
            default: state_d = SEARCH;
        endcase

        if (timeout) begin
            state_d      = SEARCH;
            h_seen_d     = 1'b0;
            v_seen_d     = 1'b0;
            hlen_valid_d = 1'b0;
            frame_bad_d  = 1'b0;
            good_cnt_d   = '0;
        end
    end

    always_comb begin
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        line_act_d = line_act_q | s_blank_q;
        // Looking ahead at blank_n holds px_x on the last active pixel.
        if (hfall) begin
            px_x_d = '0;
        end else if (s_blank_q && blank_n) begin
            px_x_d = px_x_q + 1'b1;
        end
        if (hfall) begin
            line_act_d = 1'b0;
        end
        if (vfall) begin
            px_y_d = '0;
        end else if (hfall && line_act_q) begin
            px_y_d = px_y_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= SEARCH;
            s_hs_q         <= 1'b1;
            s_vs_q         <= 1'b1;
            s_blank_q      <= 1'b0;
            p_hs_q         <= 1'b1;
            p_vs_q         <= 1'b1;
            h_cnt_q        <= '0;
            lo_cnt_q       <= '0;
            l_cnt_q        <= '0;
            vl_cnt_q       <= '0;
            good_cnt_q     <= '0;
            h_seen_q       <= 1'b0;
            v_seen_q       <= 1'b0;
            hlen_valid_q   <= 1'b0;
            frame_bad_q    <= 1'b0;
            line_act_q     <= 1'b0;
            h_period_q     <= '0;
            h_sync_len_q   <= '0;
            v_lines_q      <= '0;
            v_sync_len_q   <= '0;
            line_strobe_q  <= 1'b0;
            frame_strobe_q <= 1'b0;
            err_h_q        <= 1'b0;
            err_v_q        <= 1'b0;
            px_x_q         <= '0;
            px_y_q         <= '0;
        end else begin
            state_q        <= state_d;
            s_hs_q         <= s_hs_d;
            s_vs_q         <= s_vs_d;
            s_blank_q      <= s_blank_d;
            p_hs_q         <= p_hs_d;
            p_vs_q         <= p_vs_d;
            h_cnt_q        <= h_cnt_d;
            lo_cnt_q       <= lo_cnt_d;
            l_cnt_q        <= l_cnt_d;
            vl_cnt_q       <= vl_cnt_d;
            good_cnt_q     <= good_cnt_d;
            h_seen_q       <= h_seen_d;
            v_seen_q       <= v_seen_d;
            hlen_valid_q   <= hlen_valid_d;
            frame_bad_q    <= frame_bad_d;
            line_act_q     <= line_act_d;
            h_period_q     <= h_period_d;
            h_sync_len_q   <= h_sync_len_d;
            v_lines_q      <= v_lines_d;
            v_sync_len_q   <= v_sync_len_d;
            line_strobe_q  <= line_strobe_d;
            frame_strobe_q <= frame_strobe_d;
            err_h_q        <= err_h_d;
            err_v_q        <= err_v_d;
            px_x_q         <= px_x_d;
            px_y_q         <= px_y_d;
        end
    end

    assign h_period     = h_period_q;
    assign h_sync_len   = h_sync_len_q;
    assign v_lines      = v_lines_q;
    assign v_sync_len   = v_sync_len_q;
    assign line_strobe  = line_strobe_q;
    assign frame_strobe = frame_strobe_q;
    assign locked       = (state_q == LOCKED);
    assign err_h        = err_h_q;
    assign err_v        = err_v_q;
    assign px_x         = px_x_q;
    assign px_y         = px_y_q;
    assign px_valid     = s_blank_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a scaled-down raster
// (40 clocks x 20 lines, 24x12 active) to keep frames short.
module tb_vga_sync_monitor;

    localparam int HS  = 8;
    localparam int HT  = 40;
    localparam int VSN = 2;
    localparam int VT  = 20;
    localparam int HB  = 12;
    localparam int HA  = 24;
    localparam int VB  = 4;
    localparam int VA  = 12;
    localparam int CW  = 12;

    typedef struct {
        int per;
        int len;
        int err;
    } lexp_t;

    typedef struct {
        int lines;
        int vsl;
        int err;
        int lck;
    } fexp_t;

    typedef struct {
        int x;
        int y;
    } pexp_t;

    logic          clk;
    logic          rst_n;
    logic          hs;
    logic          vs;
    logic          blank_n;
    logic [CW-1:0] h_period;
    logic [CW-1:0] h_sync_len;
    logic [CW-1:0] v_lines;
    logic [CW-1:0] v_sync_len;
    logic          line_strobe;
    logic          frame_strobe;
    logic          locked;
    logic          err_h;
    logic          err_v;
    logic [9:0]    px_x;
    logic [9:0]    px_y;
    logic          px_valid;

    vga_sync_monitor #(
        .H_SYNC(HS), .H_TOTAL(HT), .V_SYNC(VSN),
        .V_TOTAL(VT), .LOCK_FRAMES(2), .CW(CW)
    ) dut (
        .clk(clk), .reset(rst_n), .hs(hs), .vs(vs),
        .blank_n(blank_n), .h_period(h_period),
        .h_sync_len(h_sync_len), .v_lines(v_lines),
        .v_sync_len(v_sync_len), .line_strobe(line_strobe),
        .frame_strobe(frame_strobe), .locked(locked),
        .err_h(err_h), .err_v(err_v), .px_x(px_x),
        .px_y(px_y), .px_valid(px_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    lexp_t line_q[$];
    fexp_t frame_q[$];
    pexp_t px_q[$];

    int prev_l, prev_w, row;
    bit fresh, armed;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " h_period"}, int'(h_period), 0);
        chk({tag, " h_sync_len"}, int'(h_sync_len), 0);
        chk({tag, " v_lines"}, int'(v_lines), 0);
        chk({tag, " v_sync_len"}, int'(v_sync_len), 0);
        chk({tag, " px_x"}, int'(px_x), 0);
        chk({tag, " px_y"}, int'(px_y), 0);
        chk({tag, " flags"}, int'({line_strobe, frame_strobe, err_h,
                                   err_v, locked, px_valid}), 0);
    endtask

    task automatic drive_line(input bit vlow, input int vline,
                              input int w, input int len, input int ncyc);
        lexp_t e;
        pexp_t p;
        bit act;
        if (!fresh) begin
            e.per = prev_l;
            e.len = prev_w;
            e.err = (armed && (prev_l != HT || prev_w != HS)) ? 1 : 0;
            line_q.push_back(e);
        end
        fresh  = 1'b0;
        prev_l = len;
        prev_w = w;
        act = (vline >= VB) && (vline < VB + VA);
        for (int c = 0; c < ncyc; c++) begin
            hs      = (c >= w);
            vs      = !vlow;
            blank_n = act && (c >= HB) && (c < HB + HA);
            if (blank_n) begin
                p.x = c - HB;
                p.y = row;
                px_q.push_back(p);
            end
            @(posedge clk);
            #1;
        end
        if (act) row++;
    endtask

    task automatic frame(input int total, input int start, input int stop,
                         input int bad, input int e_lines, input int e_vsl,
                         input int e_err, input int e_lck);
        fexp_t f;
        if (start == 0) begin
            row     = 0;
            f.lines = e_lines;
            f.vsl   = e_vsl;
            f.err   = e_err;
            f.lck   = e_lck;
            frame_q.push_back(f);
        end
        for (int l = start; l < stop && l < total; l++) begin
            drive_line(l < VSN, l, (l == bad) ? HS - 1 : HS, HT, HT);
            if (l == 0) armed = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        lexp_t le;
        fexp_t fe;
        pexp_t pe;
        if (line_strobe) begin
            if (line_q.size() == 0) begin
                chk("unexpected line_strobe", 1, 0);
            end else begin
                le = line_q.pop_front();
                chk("h_period", int'(h_period), le.per);
                chk("h_sync_len", int'(h_sync_len), le.len);
                chk("err_h", int'(err_h), le.err);
            end
        end else if (err_h) begin
            chk("err_h without line_strobe", 1, 0);
        end
        if (err_h) begin
            chk("locked on err_h", int'(locked), 0);
        end
        if (frame_strobe) begin
            if (frame_q.size() == 0) begin
                chk("unexpected frame_strobe", 1, 0);
            end else begin
                fe = frame_q.pop_front();
                chk("v_lines", int'(v_lines), fe.lines);
                chk("v_sync_len", int'(v_sync_len), fe.vsl);
                chk("err_v", int'(err_v), fe.err);
                chk("locked at vfall", int'(locked), fe.lck);
            end
        end else if (err_v) begin
            chk("err_v without frame_strobe", 1, 0);
        end
        if (px_valid) begin
            if (px_q.size() == 0) begin
                chk("unexpected px_valid", 1, 0);
            end else begin
                pe = px_q.pop_front();
                chk("px_x", int'(px_x), pe.x);
                chk("px_y", int'(px_y), pe.y);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        hs      = 1'b1;
        vs      = 1'b1;
        blank_n = 1'b0;
        fresh   = 1'b1;
        armed   = 1'b0;
        row     = 0;
        prev_l  = 0;
        prev_w  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        frame(VT, 5, VT, -1, 0, 0, 0, 0);
        frame(VT, 0, VT, -1, 0, 0, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 1);
        frame(VT, 0, VT, 6, 20, 2, 0, 1);
        frame(VT, 0, VT, -1, 20, 2, 1, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 1);
        frame(19, 0, 19, -1, 20, 2, 0, 1);
        frame(VT, 0, VT, -1, 19, 2, 1, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 1);
        chk("locked before gap", int'(locked), 1);

        hs      = 1'b1;
        vs      = 1'b1;
        blank_n = 1'b0;
        repeat (5000) @(posedge clk);
        #1;
        fresh = 1'b1;
        armed = 1'b0;
        chk("locked after gap", int'(locked), 0);
        chk("h_period kept", int'(h_period), 40);
        chk("v_lines kept", int'(v_lines), 20);

        frame(VT, 5, VT, -1, 0, 0, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 1);

        frame(VT, 0, 3, -1, 20, 2, 0, 1);
        drive_line(1'b0, 3, HS, HT, 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        hs      = 1'b1;
        vs      = 1'b1;
        blank_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fresh = 1'b1;
        armed = 1'b0;
        row   = 0;

        frame(VT, 5, VT, -1, 0, 0, 0, 0);
        frame(VT, 0, VT, -1, 0, 0, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 0);
        frame(VT, 0, VT, -1, 20, 2, 0, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("line queue drained", line_q.size(), 0);
        chk("frame queue drained", frame_q.size(), 0);
        chk("pixel queue drained", px_q.size(), 0);
        chk("locked at end", int'(locked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
